rrx_cmd_router: RTL and testbench

- Packet-level router for the 32-bit rasterizer command stream; fans one AXI-Stream command input out to CHANNELS rasterizer pipelines (IF/EF instances or TMU-split cores).
- Header beat of each packet selects the target channel, or broadcast to all; the remaining beats up to and including tlast follow the same route.
- Sits between the host command DMA and the rasterizer cores; generalises single-core variant selection to N runtime-selected channels.

---
 rtl/rrx_cmd_router_pkg.sv | 35 +++
 rtl/rrx_cmd_bcast_reg.sv | 37 +++
 rtl/rrx_cmd_router.sv | 153 +++++++++++++++
 tb/tb_rrx_cmd_router.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrx_cmd_router_pkg.sv
// rrx_cmd_router_pkg: FSM state type and header-decode helpers shared by the command router.
package rrx_cmd_router_pkg;

    localparam int MAX_CHANNELS = 8;

    // Full-width all-ones; callers keep only the low SEL_WIDTH bits as the broadcast code.
    localparam logic [31:0] BROADCAST_SEL = '1;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DRAIN
    } router_state_t;

    function automatic int unsigned broadcast_code(input int unsigned sel_width);
        return BROADCAST_SEL >> (32 - sel_width);
    endfunction

    // Map a header select code to a channel mask; an unknown channel yields an empty mask.
    function automatic logic [MAX_CHANNELS-1:0] sel_to_mask(input int unsigned sel,
                                                            input int unsigned channels,
                                                            input int unsigned sel_width);
        logic [MAX_CHANNELS-1:0] mask;
        logic                    bcast;
        mask  = '0;
        bcast = (sel == broadcast_code(sel_width));
        for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
            if (i < channels && (bcast || sel == i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/rrx_cmd_bcast_reg.sv
// rrx_cmd_bcast_reg: single-beat output register shared by all channels, with a
// per-channel pending mask so each channel takes the beat exactly once.
module rrx_cmd_bcast_reg #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [CHANNELS-1:0]   load_mask,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic [CHANNELS-1:0]   m_tready,
    output logic [CHANNELS-1:0]   pending,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    output logic                  free
);

    // Free when every still-pending channel is taking the beat this cycle.
    assign free = ((pending & ~m_tready) == '0);

    always_ff @(posedge aclk) begin
        if (reset) begin
            pending <= '0;
            data    <= '0;
            last    <= 1'b0;
        end else if (load) begin
            pending <= load_mask;
            data    <= load_data;
            last    <= load_last;
        end else begin
            pending <= pending & ~m_tready;
        end
    end

endmodule

// File: rtl/rrx_cmd_router.sv
// rrx_cmd_router: routes each command packet to the channel(s) named in its header beat.
// Define RRX_CMD_ROUTER_STATS_EN to add per-channel packet and drop counters.
module rrx_cmd_router
    import rrx_cmd_router_pkg::*;
#(
    parameter int CHANNELS         = 2,
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int SEL_LSB          = 28,
    parameter int SEL_WIDTH        = 4
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        s_cmd_axis_tvalid,
    output logic                        s_cmd_axis_tready,
    input  logic                        s_cmd_axis_tlast,
    input  logic [CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
    output logic [CHANNELS-1:0]         m_cmd_axis_tvalid,
    input  logic [CHANNELS-1:0]         m_cmd_axis_tready,
    output logic                        m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0] m_cmd_axis_tdata,
    output logic                        busy,
    output logic                        bad_sel
`ifdef RRX_CMD_ROUTER_STATS_EN
    ,
    output logic [CHANNELS*16-1:0]      stats_pkt_count,
    output logic [15:0]                 stats_drop_count
`endif
);

    // The select field must be able to name every channel and still leave the broadcast code free.
    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || SEL_WIDTH < 1 || SEL_WIDTH > 31 ||
        CHANNELS > (2 ** SEL_WIDTH) - 1 || SEL_LSB + SEL_WIDTH > CMD_STREAM_WIDTH) begin : g_bad_config
        $error("rrx_cmd_router: illegal CHANNELS / SEL_WIDTH / SEL_LSB combination");
    end

    router_state_t         state;
    router_state_t         next_state;
    logic [CHANNELS-1:0]   route_mask;
    logic [CHANNELS-1:0]   hdr_mask;
    logic [CHANNELS-1:0]   load_mask;
    logic [CHANNELS-1:0]   pending;
    logic [SEL_WIDTH-1:0]  sel_field;
    logic                  free;
    logic                  accept;
    logic                  hdr_bad;

    assign sel_field         = s_cmd_axis_tdata[SEL_LSB +: SEL_WIDTH];
    assign hdr_mask          = CHANNELS'(sel_to_mask(32'(sel_field), CHANNELS, SEL_WIDTH));
    assign s_cmd_axis_tready = free;
    assign accept            = s_cmd_axis_tvalid && free;
    assign m_cmd_axis_tvalid = pending;
    assign busy              = (state != IDLE) || (pending != '0);

    always_ff @(posedge aclk) begin
        if (reset) begin
            state      <= IDLE;
            route_mask <= '0;
            bad_sel    <= 1'b0;
        end else begin
            state   <= next_state;
            bad_sel <= hdr_bad;
            if (accept && state == IDLE) begin
                route_mask <= hdr_mask;
            end
        end
    end

    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!s_cmd_axis_tlast) begin
                        next_state = (hdr_mask != '0) ? ROUTE : DRAIN;
                    end
                end
                ROUTE, DRAIN: begin
                    if (s_cmd_axis_tlast) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // DRAIN loads an empty mask, so its beats are accepted and simply vanish.
    always_comb begin
        load_mask = '0;
        hdr_bad   = 1'b0;
        case (state)
            IDLE: begin
                load_mask = hdr_mask;
                hdr_bad   = accept && (hdr_mask == '0);
            end
            ROUTE:   load_mask = route_mask;
            default: load_mask = '0;
        endcase
    end

    rrx_cmd_bcast_reg #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (CMD_STREAM_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .reset     (reset),
        .load      (accept),
        .load_mask (load_mask),
        .load_data (s_cmd_axis_tdata),
        .load_last (s_cmd_axis_tlast),
        .m_tready  (m_cmd_axis_tready),
        .pending   (pending),
        .data      (m_cmd_axis_tdata),
        .last      (m_cmd_axis_tlast),
        .free      (free)
    );

`ifdef RRX_CMD_ROUTER_STATS_EN
    logic [CHANNELS-1:0] taken;
    logic [15:0]         pkt_count [CHANNELS];
    logic [15:0]         drop_count;
    logic                drop_event;

    assign taken      = pending & m_cmd_axis_tready;
    assign drop_event = accept && s_cmd_axis_tlast &&
                        ((state == IDLE && hdr_mask == '0) || state == DRAIN);

    // A packet counts per channel when that channel takes its tlast beat.
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pkt_count[i] <= '0;
            end
            drop_count <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (taken[i] && m_cmd_axis_tlast) begin
                    pkt_count[i] <= pkt_count[i] + 16'd1;
                end
            end
            if (drop_event) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stats_pack
        assign stats_pkt_count[g*16 +: 16] = pkt_count[g];
    end
    assign stats_drop_count = drop_count;
`endif

endmodule

// File: tb/tb_rrx_cmd_router.sv
// tb_rrx_cmd_router: directed and randomized packets checked against a packet-level
// scoreboard that predicts, per channel, which beats must appear.
module tb_rrx_cmd_router;

    localparam int CH = 2;

    logic          aclk = 1'b0;
    logic          reset;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [31:0]   s_tdata;
    logic [CH-1:0] m_tvalid;
    logic [CH-1:0] m_tready;
    logic          m_tlast;
    logic [31:0]   m_tdata;
    logic          busy;
    logic          bad_sel;
`ifdef RRX_CMD_ROUTER_STATS_EN
    logic [CH*16-1:0] stats_pkt_count;
    logic [15:0]      stats_drop_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic          rand_ready   = 1'b0;
    logic [CH-1:0] forced_ready = '1;

    // Scoreboard: expected {tlast, tdata} per channel, in delivery order.
    logic [32:0] exp_q [CH][$];
    int          ch_beats [CH];
    int          bad_seen = 0;
    int          bad_exp  = 0;
    bit          model_in_pkt = 1'b0;
    logic [CH-1:0] model_dest = '0;
    int          model_pkts [CH];
    int          model_drops = 0;

    always #5 aclk = ~aclk;

    rrx_cmd_router #(
        .CHANNELS         (CH),
        .CMD_STREAM_WIDTH (32),
        .SEL_LSB          (28),
        .SEL_WIDTH        (4)
    ) dut (
        .aclk              (aclk),
        .reset             (reset),
        .s_cmd_axis_tvalid (s_tvalid),
        .s_cmd_axis_tready (s_tready),
        .s_cmd_axis_tlast  (s_tlast),
        .s_cmd_axis_tdata  (s_tdata),
        .m_cmd_axis_tvalid (m_tvalid),
        .m_cmd_axis_tready (m_tready),
        .m_cmd_axis_tlast  (m_tlast),
        .m_cmd_axis_tdata  (m_tdata),
        .busy              (busy),
        .bad_sel           (bad_sel)
`ifdef RRX_CMD_ROUTER_STATS_EN
        ,
        .stats_pkt_count   (stats_pkt_count),
        .stats_drop_count  (stats_drop_count)
`endif
    );

    always @(posedge aclk) begin
        cyc++;
        #2;
        m_tready = rand_ready ? CH'($urandom) : forced_ready;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle, where they are stable until the next rising edge.
    always @(negedge aclk) begin
        logic [32:0] e;
        if (!reset) begin
            if (bad_sel) bad_seen++;
            for (int i = 0; i < CH; i++) begin
                if (m_tvalid[i] && m_tready[i]) begin
                    ch_beats[i]++;
                    if (exp_q[i].size() == 0) begin
                        checkOutput($sformatf("ch%0d_extra_beat", i), 64'(m_tvalid[i]), 64'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        checkOutput($sformatf("ch%0d_beat", i), 64'({m_tlast, m_tdata}), 64'(e));
                    end
                end
            end
        end
    end

    task automatic modelBeat(input logic [31:0] d, input logic l);
        int sel;
        if (!model_in_pkt) begin
            sel = int'(d[31:28]);
            if (sel == 15)     model_dest = '1;
            else if (sel < CH) model_dest = CH'(1) << sel;
            else begin
                model_dest = '0;
                bad_exp++;
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (model_dest[i]) begin
                exp_q[i].push_back({l, d});
                if (l) model_pkts[i]++;
            end
        end
        if (l && model_dest == '0) model_drops++;
        model_in_pkt = !l;
    endtask

    task automatic modelReset();
        for (int i = 0; i < CH; i++) begin
            exp_q[i].delete();
            model_pkts[i] = 0;
        end
        model_in_pkt = 1'b0;
        model_dest   = '0;
        model_drops  = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] d, input logic l);
        int guard;
        guard    = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(negedge aclk);
        while (!s_tready && guard < 500) begin
            @(negedge aclk);
            guard++;
        end
        if (!s_tready) checkOutput("accept_timeout", 64'(s_tready), 64'd1);
        else           modelBeat(d, l);
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drainWait(input string tag);
        int guard;
        int left;
        guard = 0;
        left  = 1;
        while ((left != 0 || busy) && guard < 2000) begin
            @(posedge aclk);
            #1;
            guard++;
            left = 0;
            for (int i = 0; i < CH; i++) left += exp_q[i].size();
        end
        checkOutput({tag, "_left"}, 64'(left), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int b0;
        int b1;
        int bad0;
        int start;
        int len;
        int sel;
        logic [31:0] d;

        for (int i = 0; i < CH; i++) begin
            ch_beats[i]   = 0;
            model_pkts[i] = 0;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        reset    = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_tdata",  64'(m_tdata),  64'd0);
        checkOutput("rst_tlast",  64'(m_tlast),  64'd0);
        checkOutput("rst_busy",   64'(busy),     64'd0);
        checkOutput("rst_bad_sel", 64'(bad_sel), 64'd0);
        checkOutput("rst_tready", 64'(s_tready), 64'd1);
        reset = 1'b0;
        @(posedge aclk);
        #1;

        $display("[TB] three packets to ch0 plus one broadcast");
        applyStimulus(32'h0000_0011, 1'b1);
        applyStimulus(32'h0000_0012, 1'b1);
        applyStimulus(32'h0000_0013, 1'b1);
        applyStimulus(32'hF000_0022, 1'b1);
        drainWait("stats_pkts");
`ifdef RRX_CMD_ROUTER_STATS_EN
        checkOutput("stats_ch0", 64'(stats_pkt_count[15:0]),  64'd4);
        checkOutput("stats_ch1", 64'(stats_pkt_count[31:16]), 64'd1);
`endif

        $display("[TB] 4-beat packet to ch1 with all readies high");
        b0    = ch_beats[0];
        b1    = ch_beats[1];
        start = cyc;
        applyStimulus(32'h1000_0001, 1'b0);
        checkOutput("t1_hdr_tvalid", 64'(m_tvalid), 64'b10);
        applyStimulus(32'hA5A5_0002, 1'b0);
        checkOutput("t1_beat2_tvalid", 64'(m_tvalid), 64'b10);
        applyStimulus(32'hA5A5_0003, 1'b0);
        applyStimulus(32'hA5A5_0004, 1'b1);
        checkOutput("t1_stream_cycles", 64'(cyc - start), 64'd4);
        drainWait("t1");
        checkOutput("t1_ch0_beats", 64'(ch_beats[0] - b0), 64'd0);
        checkOutput("t1_ch1_beats", 64'(ch_beats[1] - b1), 64'd4);

        $display("[TB] broadcast with ch1 stalled");
        b0 = ch_beats[0];
        b1 = ch_beats[1];
        forced_ready = 2'b01;
        applyStimulus(32'hF000_00B0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            checkOutput("t2_stall_tready", 64'(s_tready), 64'd0);
            if (k > 0) checkOutput("t2_ch0_once", 64'(m_tvalid), 64'b10);
        end
        forced_ready = 2'b11;
        applyStimulus(32'h0000_00B1, 1'b1);
        drainWait("t2");
        checkOutput("t2_ch0_beats", 64'(ch_beats[0] - b0), 64'd2);
        checkOutput("t2_ch1_beats", 64'(ch_beats[1] - b1), 64'd2);

        $display("[TB] header naming a nonexistent channel");
        b0   = ch_beats[0];
        b1   = ch_beats[1];
        bad0 = bad_seen;
        applyStimulus(32'h5000_0000, 1'b0);
        checkOutput("t3_busy_drain", 64'(busy), 64'd1);
        applyStimulus(32'h5000_0001, 1'b0);
        applyStimulus(32'h5000_0002, 1'b1);
        checkOutput("t3_busy_after", 64'(busy), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("t3_bad_pulse", 64'(bad_seen - bad0), 64'd1);
        checkOutput("t3_no_output", 64'(ch_beats[0] + ch_beats[1] - b0 - b1), 64'd0);
        applyStimulus(32'h0000_0C00, 1'b0);
        applyStimulus(32'h0000_0C01, 1'b1);
        drainWait("t3");
        checkOutput("t3_ch0_after", 64'(ch_beats[0] - b0), 64'd2);

        $display("[TB] back-to-back single-beat packets");
        start = cyc;
        applyStimulus(32'h0000_0D00, 1'b1);
        checkOutput("t4_first", 64'(m_tvalid), 64'b01);
        applyStimulus(32'h1000_0D01, 1'b1);
        checkOutput("t4_second", 64'(m_tvalid), 64'b10);
        checkOutput("t4_cycles", 64'(cyc - start), 64'd2);
        drainWait("t4");

        $display("[TB] reset with a beat pending on ch1");
        forced_ready = 2'b00;
        applyStimulus(32'h1000_0E00, 1'b0);
        @(posedge aclk);
        #1;
        checkOutput("t5_pending", 64'(m_tvalid), 64'b10);
        reset = 1'b1;
        @(posedge aclk);
        #1;
        reset = 1'b0;
        modelReset();
        checkOutput("t5_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        forced_ready = 2'b11;
        applyStimulus(32'h0000_0000, 1'b1);
        checkOutput("t5_new_hdr", 64'(m_tvalid), 64'b01);
        drainWait("t5");

        $display("[TB] randomized packets and readies");
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 4));
            case ($urandom_range(0, 5))
                0, 1:    sel = 0;
                2, 3:    sel = 1;
                4:       sel = 15;
                default: sel = int'($urandom_range(2, 14));
            endcase
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                if (b == 0) d[31:28] = 4'(sel);
                applyStimulus(d, b == len - 1);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge aclk);
                    #1;
                end
            end
        end
        rand_ready   = 1'b0;
        forced_ready = '1;
        drainWait("rand");
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("bad_sel_total", 64'(bad_seen), 64'(bad_exp));
`ifdef RRX_CMD_ROUTER_STATS_EN
        checkOutput("stats_final_ch0", 64'(stats_pkt_count[15:0]),  64'(model_pkts[0] % 65536));
        checkOutput("stats_final_ch1", 64'(stats_pkt_count[31:16]), 64'(model_pkts[1] % 65536));
        checkOutput("stats_drops",     64'(stats_drop_count),       64'(model_drops % 65536));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
